// File: rtl/av2_stream_pkg.sv
// av2_stream_pkg: shared tuser bit positions, frame checker error codes,
// checker state type and the YUV420 frame byte-count helper.
package av2_stream_pkg;

    localparam int TUSER_SOF = 1;
    localparam int TUSER_EOF = 0;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_LEN     = 3'd1;
    localparam logic [2:0] ERR_KEEP    = 3'd2;
    localparam logic [2:0] ERR_NOSTART = 3'd3;
    localparam logic [2:0] ERR_RESTART = 3'd4;

    typedef enum logic {
        CHK_IDLE     = 1'b0,
        CHK_IN_FRAME = 1'b1
    } chk_state_t;

    // Luma plus two quarter-size chroma planes, all in 32-bit arithmetic.
    function automatic logic [31:0] frame_bytes(
        input logic [15:0] w,
        input logic [15:0] h
    );
        logic [31:0] luma;
        luma = {16'd0, w} * {16'd0, h};
        return luma + ((luma >> 2) << 1);
    endfunction

endpackage

// File: rtl/av2_sync_fifo.sv
// av2_sync_fifo: generic synchronous FIFO, first-word-fall-through output.
// Ports: clk, rst_n, flush, wr_en/wr_data, rd_en/rd_data, full, empty, level.
module av2_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             push;
    logic             pop;

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign push  = wr_en && !full && !flush;
    assign pop   = rd_en && !empty && !flush;
    assign level = count;

    // Empty reads return zero so the output is clean out of reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + LW'(1);
            end else if (pop && !push) begin
                count <= count - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/av2_out_stream_fifo.sv
// av2_out_stream_fifo: output beat buffer plus per-frame integrity checker.
// Ports: s_axis_* in, m_axis_* out, fifo_level, frame_done/err, err_code,
// frame_count. Checker built only with AV2_OUT_FIFO_CHECK_EN defined.
module av2_out_stream_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [15:0]               frame_width,
    input  logic [15:0]               frame_height,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic [1:0]                s_axis_tuser,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic [1:0]                m_axis_tuser,
    input  logic                      m_axis_tready,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      frame_done,
    output logic                      frame_err,
    output logic [2:0]                err_code,
    output logic [15:0]               frame_count
);

    import av2_stream_pkg::*;

    localparam int KW = DATA_WIDTH / 8;
    localparam int FW = DATA_WIDTH + KW + 3;

    logic          rdy_q;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [FW-1:0] rd_word;

    // Holds tready low through reset and the first edge after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    assign s_axis_tready = rdy_q && !full && !flush;
    assign push          = s_axis_tvalid && s_axis_tready;
    assign m_axis_tvalid = !empty;
    assign pop           = m_axis_tvalid && m_axis_tready;

    av2_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .wr_en   (push),
        .wr_data ({s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser}),
        .rd_en   (pop),
        .rd_data (rd_word),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = rd_word;

`ifdef AV2_OUT_FIFO_CHECK_EN

    chk_state_t    state;
    chk_state_t    state_nx;
    logic [31:0]   acc;
    logic [31:0]   acc_nx;
    logic [31:0]   acc_sum;
    logic [31:0]   beat_bytes;
    logic [31:0]   expected;
    logic          flag;
    logic          flag_nx;
    logic          beat_flag;
    logic          sof;
    logic          keep_bad;
    logic          restart;
    logic          nostart;
    logic          len_bad;
    logic [KW-1:0] keep_inc;
    logic [2:0]    code;
    logic          done_nx;
    logic          err_nx;
    logic [2:0]    code_nx;
    logic [15:0]   count_nx;
    logic          done_q;
    logic          err_q;
    logic [2:0]    code_q;
    logic [15:0]   count_q;

    assign expected = frame_bytes(frame_width, frame_height);

    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < KW; i++) begin
            beat_bytes = beat_bytes + 32'(s_axis_tkeep[i]);
        end
    end

    always_comb begin
        // Contiguous low-order keep: k & (k+1) clears only for 2^n-1.
        keep_inc = s_axis_tkeep + KW'(1);
        keep_bad = (s_axis_tkeep == '0) ||
                   ((s_axis_tkeep & keep_inc) != '0);
        sof      = s_axis_tuser[TUSER_SOF];
        restart  = sof && (state == CHK_IN_FRAME);
        nostart  = !sof && (state == CHK_IDLE);
        acc_sum  = sof ? beat_bytes : acc + beat_bytes;
        len_bad  = s_axis_tlast && (acc_sum != expected);

        if (keep_bad) begin
            code = ERR_KEEP;
        end else if (restart) begin
            code = ERR_RESTART;
        end else if (nostart) begin
            code = ERR_NOSTART;
        end else if (len_bad) begin
            code = ERR_LEN;
        end else begin
            code = ERR_NONE;
        end

        // A start beat opens a fresh per-frame error history.
        beat_flag = (sof ? 1'b0 : flag) | (code != ERR_NONE);
    end

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        flag_nx  = flag;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        code_nx  = ERR_NONE;
        count_nx = count_q;
        if (flush) begin
            state_nx = CHK_IDLE;
            acc_nx   = '0;
            flag_nx  = 1'b0;
        end else if (push) begin
            done_nx = s_axis_tlast;
            err_nx  = (code != ERR_NONE);
            code_nx = code;
            if (s_axis_tlast) begin
                state_nx = CHK_IDLE;
                acc_nx   = '0;
                flag_nx  = 1'b0;
                if (!beat_flag) begin
                    count_nx = count_q + 16'd1;
                end
            end else begin
                state_nx = sof ? CHK_IN_FRAME : state;
                acc_nx   = acc_sum;
                flag_nx  = beat_flag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CHK_IDLE;
            acc     <= '0;
            flag    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            count_q <= '0;
        end else begin
            state   <= state_nx;
            acc     <= acc_nx;
            flag    <= flag_nx;
            done_q  <= done_nx;
            err_q   <= err_nx;
            code_q  <= code_nx;
            count_q <= count_nx;
        end
    end

    assign frame_done  = done_q;
    assign frame_err   = err_q;
    assign err_code    = code_q;
    assign frame_count = count_q;

`else

    logic unused_cfg;
    assign unused_cfg  = ^{frame_width, frame_height};

    assign frame_done  = 1'b0;
    assign frame_err   = 1'b0;
    assign err_code    = ERR_NONE;
    assign frame_count = '0;

`endif

endmodule

// File: doc/av2_out_stream_fifo.md
# av2_out_stream_fifo

- Sits directly downstream of the decoder's AXI4-Stream frame output controller and feeds the system-side video sink.
- Buffers 128-bit YUV420 beats (tdata/tkeep/tlast/tuser) in a synchronous FIFO, so sink backpressure never stalls framebuffer readout for more than DEPTH beats.
- Checks each accepted frame for framing and length integrity and reports a per-frame result.

## Interface
Parameters:
- DATA_WIDTH, 128, tdata width; tkeep width is DATA_WIDTH/8.
- DEPTH, 16, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of FIFO and checker.
- frame_width  in  16  luma width in pixels.
- frame_height  in  16  luma height in pixels.
- s_axis_tdata  in  DATA_WIDTH  upstream beat data.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tready  out  1  high when not full and flush is low.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tkeep  in  DATA_WIDTH/8  byte enables.
- s_axis_tuser  in  2  [1] frame start, [0] frame end.
- m_axis_tdata / tvalid / tlast / tkeep / tuser  out  same widths  downstream beat.
- m_axis_tready  in  1  downstream ready.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- frame_done  out  1  one-cycle pulse when a frame's tlast beat is accepted.
- frame_err  out  1  one-cycle pulse on any framing error.
- err_code  out  3  error cause, valid with frame_err.
- frame_count  out  16  count of frames completed without error; wraps at 65535 -> 0.

## Operation
- Push: s_axis_tvalid && s_axis_tready.
- Pop: m_axis_tvalid && m_axis_tready.
- FIFO stores {tdata, tkeep, tlast, tuser}. Output is first-word-fall-through from the entry at the read pointer. Pointers wrap modulo DEPTH.
- Full: s_axis_tready=0. A push and pop in the same cycle when not full and not empty leaves the level unchanged.
- Empty: m_axis_tvalid=0. There is no combinational pass-through.
- Checker observes accepted input beats only.
- Checker states:
  - IDLE -> IN_FRAME on a beat with tuser[1]=1 and tlast=0.
  - IN_FRAME -> IDLE on tlast.
  - A beat with both tuser[1] and tlast is a single-beat frame and stays in IDLE.
- Byte accumulator (32-bit) adds popcount(tkeep) per beat. A start beat loads it rather than adding.
- Expected bytes = W*H + ((W*H)>>2)*2, computed in 32 bits.
- err_code values:
  - 1 LEN: tlast with accumulated bytes != expected.
  - 2 KEEP: tkeep not of the form 2^n-1 (n=1..16).
  - 3 NOSTART: data beat or tlast while IDLE without tuser[1].
  - 4 RESTART: tuser[1] while IN_FRAME; counting restarts from this beat.
- Error priority when several hit on one beat: KEEP > RESTART > NOSTART > LEN.
- Every beat, including erroneous ones, is forwarded unchanged.
- frame_done pulses on every accepted tlast, errored or not. frame_count increments only if no error occurred since the frame's start beat (sticky per-frame flag).
- flush: empties the FIFO, checker -> IDLE, accumulator cleared. frame_count is retained. A flush coinciding with push or pop overrides both; tready is low during flush.

## Timing
- Reset values:
  - m_axis_tvalid=0, s_axis_tready=0 while rst_n is low, then 1.
  - fifo_level=0, frame_done=0, frame_err=0, err_code=0, frame_count=0.
  - m_axis_tdata/tkeep/tlast/tuser=0.
- Latency: a beat pushed at edge N is presented on m_axis at N+1 (1-cycle minimum).
- Handshake: m_axis outputs stay stable while tvalid && !tready.
- s_axis_tready depends only on registered level and flush. It has no combinational path from m_axis_tready.
- frame_done, frame_err, err_code are registered and assert the cycle after the offending or tlast push.
- Reset mid-frame: all state is cleared asynchronously and in-flight beats are lost. The first beat after reset without tuser[1] raises NOSTART.

## Configuration
- Macro AV2_OUT_FIFO_CHECK_EN.
- Defined: the frame checker, frame_done, frame_err, err_code and frame_count are implemented.
- Undefined: checker logic is removed. Those outputs are tied to 0 and the block is a pure FIFO.

## Structure
- Shared package av2_stream_pkg holds the tuser bit positions (TUSER_SOF=1, TUSER_EOF=0) and the err_code localparams (ERR_NONE, ERR_LEN, ERR_KEEP, ERR_NOSTART, ERR_RESTART).
- One sub-module, av2_sync_fifo: generic width/depth FIFO with FWFT output, level and synchronous flush.
- The checker lives in the top.

## Test plan
- 64x64 frame, 384 full beats (tkeep=FFFF, first tuser=10, last tlast with tuser=01), sink always ready -> frame_done once, frame_err never, frame_count=1, output beats identical to input.
- Same frame, m_axis_tready low for 40 cycles from beat 5 -> tready drops after level reaches 16, fifo_level=16, no beat lost or reordered.
- 64x64 frame with last beat tkeep=0x0FFF -> LEN error (6140 != 6144), err_code=1, frame_done pulses, frame_count unchanged.
- Mid-frame beat with tkeep=0x00F0 -> KEEP error, err_code=2, beat still forwarded.
- tlast beat arriving in IDLE with tuser=00 -> err_code=3. A second tuser[1] mid-frame -> err_code=4 and the counter restarts.
- flush asserted with 10 beats buffered mid-frame -> next cycle fifo_level=0, m_axis_tvalid=0, checker IDLE. A following clean frame completes with no error.
